fft_frame_loader: RTL

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_frame_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: fills one bank from a sample stream while the other bank drives the FFT.
// Optional macro FRAME_LOADER_ZEROPAD_EN: only the lower half of each frame is filled, upper half reads 0.
module fft_frame_loader #(
  parameter int FFT_POINTS = 1024,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] frame_real [0:FFT_POINTS-1],
  output logic [DATA_WIDTH-1:0] frame_imag [0:FFT_POINTS-1],
  output logic                  start_fft,
  input  logic                  fft_data_valid,
  output logic [15:0]           frames_sent
);

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam int CNT_W = IDX_W + 1;
`ifdef FRAME_LOADER_ZEROPAD_EN
  localparam int FILL_LEN = FFT_POINTS / 2;
`else
  localparam int FILL_LEN = FFT_POINTS;
`endif
  localparam int BANK_AW = $clog2(FILL_LEN);
  localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(FILL_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  // bank_sel_q names the read bank; the write bank is always the other one
  logic               bank_sel_q, bank_sel_d;
  logic [15:0]        frames_sent_q, frames_sent_d;
  logic               fdv_prev_q;
  logic [DATA_WIDTH-1:0] bank0_q [0:FILL_LEN-1];
  logic [DATA_WIDTH-1:0] bank1_q [0:FILL_LEN-1];
  logic               accept_s;
  logic               frame_full_s;
  logic               fdv_rise_s;
  logic [BANK_AW-1:0] wr_idx_s;

  assign sample_ready = (wr_count_q < FILL_CNT);
  assign accept_s     = sample_valid & sample_ready;
  assign frame_full_s = (wr_count_q == FILL_CNT);
  assign fdv_rise_s   = fft_data_valid & ~fdv_prev_q;
  assign wr_idx_s     = wr_count_q[BANK_AW-1:0];
  assign start_fft    = (state_q == START);
  assign frames_sent  = frames_sent_q;

  // Handoff FSM next-state and counter updates
  always_comb begin
    state_d       = state_q;
    wr_count_d    = wr_count_q;
    bank_sel_d    = bank_sel_q;
    frames_sent_d = frames_sent_q;
    if (accept_s) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end else begin
      wr_count_d = wr_count_q;
    end
    case (state_q)
      IDLE: begin
        if (frame_full_s) begin
          state_d    = START;
          bank_sel_d = ~bank_sel_q;
          wr_count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d       = BUSY;
        frames_sent_d = frames_sent_q + 16'd1;
      end
      BUSY: begin
        if (fdv_rise_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_count_q    <= '0;
      bank_sel_q    <= 1'b0;
      frames_sent_q <= 16'd0;
      fdv_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      bank_sel_q    <= bank_sel_d;
      frames_sent_q <= frames_sent_d;
      fdv_prev_q    <= fft_data_valid;
    end
  end

  // Sample storage: accepted samples go to the bank not currently being read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FILL_LEN; i++) begin
        bank0_q[BANK_AW'(i)] <= '0;
        bank1_q[BANK_AW'(i)] <= '0;
      end
    end else if (accept_s) begin
      if (bank_sel_q) begin
        bank0_q[wr_idx_s] <= sample_in;
      end else begin
        bank1_q[wr_idx_s] <= sample_in;
      end
    end
  end

  for (genvar g = 0; g < FFT_POINTS; g++) begin : g_out
    if (g < FILL_LEN) begin : g_data
      assign frame_real[g] = bank_sel_q ? bank1_q[g] : bank0_q[g];
    end else begin : g_pad
      assign frame_real[g] = '0;
    end
    assign frame_imag[g] = '0;
  end

endmodule
